// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate data cache with
//               8 lines of 4 bytes, sitting between an 8-bit CPU data port
//               and a 32-bit-block memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;
    logic [2:0]  r_tag  [8];
    logic [31:0] r_data [8];

    logic [2:0]  w_index;
    logic [2:0]  w_tag;
    logic [4:0]  w_bit_ofs;
    logic        w_req;
    logic        w_hit;
    logic        w_wr_hit;
    logic        w_fill;
    logic [31:0] w_line;
    logic [31:0] w_wr_line;

    assign w_index   = ADDRESS[4:2];
    assign w_tag     = ADDRESS[7:5];
    assign w_bit_ofs = {ADDRESS[1:0], 3'b000};
    assign w_req     = READ | WRITE;
    assign w_line    = r_data[w_index];
    assign w_hit     = w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);

    // WRITE wins when both request lines are high.
    assign w_wr_hit  = (r_state == S_IDLE) & w_hit & WRITE;
    assign w_fill    = (r_state == S_FETCH) & ~MEM_BUSYWAIT;

    assign READDATA  = w_line[w_bit_ofs +: 8];
    assign BUSYWAIT  = w_req & ~((r_state == S_IDLE) & w_hit);

    always_comb begin
        w_wr_line = w_line;
        w_wr_line[w_bit_ofs +: 8] = WRITEDATA;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_next_state = r_dirty[w_index] ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {r_tag[w_index], w_index};
                MEM_WRITEDATA = w_line;
                if (!MEM_BUSYWAIT) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {w_tag, w_index};
                if (!MEM_BUSYWAIT) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Line storage: a fill and a write hit can never coincide (different states).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= 8'd0;
            r_dirty <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_tag[i]  <= 3'd0;
                r_data[i] <= 32'd0;
            end
        end else if (w_fill) begin
            r_data[w_index]  <= MEM_READDATA;
            r_tag[w_index]   <= w_tag;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_wr_hit) begin
            r_data[w_index]  <= w_wr_line;
            r_dirty[w_index] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Scoreboard bench for dcache_controller with a fixed-latency
//               block memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    localparam int LM = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       chk_data;
        logic [7:0] rdata;
        logic [7:0] stalls;
    } cpu_exp_t;

    typedef struct packed {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: byte at address A holds A, except block 5 = DDCCBBAA.
    logic [31:0] mem [64];
    logic [63:0] mem_wr;
    logic        mem_clr = 1'b1;
    int          mem_cnt;

    function automatic logic [31:0] mem_default(input logic [5:0] b);
        if (b == 6'd5) return 32'hDDCCBBAA;
        return {b, 2'd3, b, 2'd2, b, 2'd1, b, 2'd0};
    endfunction

    assign MEM_READDATA = mem_wr[MEM_ADDRESS] ? mem[MEM_ADDRESS] : mem_default(MEM_ADDRESS);
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < LM - 1);

    always @(posedge CLK) begin
        if (mem_clr) begin
            mem_wr  <= '0;
            mem_cnt <= 0;
        end else if (MEM_READ | MEM_WRITE) begin
            if (!MEM_BUSYWAIT) begin
                mem_cnt <= 0;
                if (MEM_WRITE) begin
                    mem[MEM_ADDRESS]    <= MEM_WRITEDATA;
                    mem_wr[MEM_ADDRESS] <= 1'b1;
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // CPU-side monitor: an access completes on a cycle with a request and no stall.
    initial begin
        int       stalls;
        cpu_exp_t e;
        stalls = 0;
        forever begin
            @(negedge CLK);
            if (RESET || !(READ || WRITE)) begin
                stalls = 0;
            end else if (BUSYWAIT) begin
                stalls++;
            end else begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    chk("stall_cycles", stalls, {24'd0, e.stalls});
                    if (e.chk_data) chk("readdata", {24'd0, READDATA}, {24'd0, e.rdata});
                end
                stalls = 0;
            end
        end
    end

    // Memory-side monitor: a transaction completes when memory is not busy.
    initial begin
        mem_exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET && (MEM_READ || MEM_WRITE)) begin
                chk("mem_rd_wr_exclusive", {31'd0, MEM_READ & MEM_WRITE}, 32'd0);
                if (!MEM_BUSYWAIT) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected_txn", 32'd1, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_is_write", {31'd0, MEM_WRITE}, {31'd0, e.is_wr});
                        chk("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, e.addr});
                        if (e.is_wr) chk("mem_writedata", MEM_WRITEDATA, e.wdata);
                    end
                end
            end
        end
    end

    task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
        mem_exp_t e;
        e.is_wr = wr;
        e.addr  = a;
        e.wdata = d;
        mem_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after the completing posedge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic cd,
                          input logic [7:0] exp_d, input logic [7:0] exp_st);
        cpu_exp_t e;
        int n;
        e.chk_data = cd;
        e.rdata    = exp_d;
        e.stalls   = exp_st;
        cpu_q.push_back(e);
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = wd;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSYWAIT && n < 60);
        if (BUSYWAIT) chk("access_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_readdata", {24'd0, READDATA}, 32'd0);
        chk("reset_busywait_idle", {31'd0, BUSYWAIT}, 32'd0);
        chk("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("reset_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
        chk("reset_mem_writedata", MEM_WRITEDATA, 32'd0);
        READ    = 1'b1;
        ADDRESS = 8'h14;
        #1;
        chk("reset_busywait_req", {31'd0, BUSYWAIT}, 32'd1);
        mem_clr = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ  = 1'b0;

        // Clean read miss then hit
        push_mem(1'b0, 6'h05, 32'h0);
        access(1'b1, 1'b0, 8'h14, 8'h00, 1'b1, 8'hAA, 8'd6);
        access(1'b1, 1'b0, 8'h15, 8'h00, 1'b1, 8'hBB, 8'd0);

        // Write hit
        access(1'b0, 1'b1, 8'h17, 8'h5A, 1'b0, 8'h00, 8'd0);
        access(1'b1, 1'b0, 8'h17, 8'h00, 1'b1, 8'h5A, 8'd0);

        // Dirty miss: write-back then fetch; the line is clean afterwards
        push_mem(1'b1, 6'h05, 32'h5ACCBBAA);
        push_mem(1'b0, 6'h0D, 32'h0);
        access(1'b1, 1'b0, 8'h34, 8'h00, 1'b1, 8'h34, 8'd11);
        push_mem(1'b0, 6'h05, 32'h0);
        access(1'b1, 1'b0, 8'h14, 8'h00, 1'b1, 8'hAA, 8'd6);

        // Write miss on an invalid line (write-allocate)
        push_mem(1'b0, 6'h38, 32'h0);
        access(1'b0, 1'b1, 8'hE0, 8'h77, 1'b0, 8'h00, 8'd6);
        access(1'b1, 1'b0, 8'hE0, 8'h00, 1'b1, 8'h77, 8'd0);
        access(1'b1, 1'b0, 8'hE1, 8'h00, 1'b1, 8'hE1, 8'd0);

        // Evicting the allocated line proves it was dirty; then READ+WRITE acts as write
        push_mem(1'b1, 6'h38, 32'hE3E2E177);
        push_mem(1'b0, 6'h00, 32'h0);
        access(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 8'd11);
        access(1'b1, 1'b1, 8'h01, 8'h99, 1'b0, 8'h00, 8'd0);
        access(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h99, 8'd0);
        push_mem(1'b1, 6'h00, 32'h03029900);
        push_mem(1'b0, 6'h38, 32'h0);
        access(1'b1, 1'b0, 8'hE0, 8'h00, 1'b1, 8'h77, 8'd11);

        // Reset during the third FETCH cycle
        READ    = 1'b1;
        ADDRESS = 8'h48;
        @(posedge CLK);
        #1;
        chk("fetch_mem_read", {31'd0, MEM_READ}, 32'd1);
        chk("fetch_mem_address", {26'd0, MEM_ADDRESS}, 32'h12);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("abort_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
        chk("abort_busywait", {31'd0, BUSYWAIT}, 32'd1);
        RESET = 1'b0;
        READ  = 1'b0;
        @(posedge CLK);
        #1;
        push_mem(1'b0, 6'h12, 32'h0);
        access(1'b1, 1'b0, 8'h48, 8'h00, 1'b1, 8'h48, 8'd6);
        push_mem(1'b0, 6'h05, 32'h0);
        access(1'b1, 1'b0, 8'h17, 8'h00, 1'b1, 8'h5A, 8'd6);

        repeat (3) @(posedge CLK);
        #1;
        chk("cpu_queue_drained", cpu_q.size(), 32'd0);
        chk("mem_queue_drained", mem_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache sitting between the single-cycle CPU's 8-bit data-memory port and the 32-bit-block data memory. It answers hits with no stall. On a miss it sequences the block write-back and fetch over the memory handshake, holding the CPU in BUSYWAIT until the access can complete. The geometry is fixed: 8 lines of 4 bytes. The 8-bit CPU address splits into tag [7:5], index [4:2] and byte offset [1:0].

## Interface
- Parameters: none. The geometry is fixed; see the summary.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  write-back block; byte 0 = bits [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

## Operation
- Per-line storage: valid, dirty, tag[2:0], data[31:0].
- hit = (READ|WRITE) & valid[index] & (tag[index]==ADDRESS[7:5]). This is combinational.
- READDATA is combinational: the byte ADDRESS[1:0] of line[index].
- BUSYWAIT is combinational: (READ|WRITE) & !(state==IDLE & hit).
- READ and WRITE both high is illegal; it is treated as WRITE.
- The CPU holds ADDRESS, WRITEDATA, READ and WRITE stable while BUSYWAIT=1. The controller does not latch them.

State machine: IDLE, WRITEBACK, FETCH.
- IDLE, read hit: no state change.
- IDLE, write hit: at the posedge, byte[offset] of line[index] is written with WRITEDATA and dirty is set to 1.
- IDLE, miss with dirty[index]=1: go to WRITEBACK.
- IDLE, miss with dirty[index]=0 (including invalid lines): go to FETCH.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index].
  - At the first posedge with MEM_BUSYWAIT=0 after entry, go to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}.
  - At the first posedge with MEM_BUSYWAIT=0 after entry, fill the line: data=MEM_READDATA, tag=ADDRESS[7:5], valid=1, dirty=0. Then go to IDLE.
- Back in IDLE the access is now a hit and completes by the hit rules.
  - Write miss: the write is applied in IDLE after the fill (write-allocate).
- MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE.
- Reset:
  - State goes to IDLE.
  - All valid and dirty bits clear; all tags and data go to 0.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - BUSYWAIT follows its equation and is therefore 1 if a request is present.
  - READDATA reads 0.
- RESET during WRITEBACK or FETCH abandons the memory transaction at that edge. Dirty data is discarded by design.

## Timing
- Read hit: 0 stall cycles; READDATA is valid in the same cycle.
- Write hit: 0 stall cycles; committed at the next posedge.
- Clean miss: 1 cycle IDLE→FETCH, then Lm memory cycles, then 1 IDLE hit cycle. BUSYWAIT is high for Lm+1 posedges.
- Dirty miss: adds Lm cycles of WRITEBACK before FETCH. BUSYWAIT is high for 2·Lm+1 posedges.
- Memory contract: memory raises MEM_BUSYWAIT before the first posedge after MEM_READ/MEM_WRITE rises.
- The controller ignores MEM_BUSYWAIT at the entry edge of a phase; the "after entry" rule enforces this.
- Line writes happen only at posedge, never combinationally.

## Test plan
1. Reset, then READ ADDRESS=0x14 (index 5) with a memory model of Lm=5 returning 0xDDCCBBAA.
   - FETCH with MEM_ADDRESS=0x05.
   - BUSYWAIT high for 6 posedges.
   - READDATA=0xAA.
   - READ 0x15 then hits with 0 stall and returns 0xBB.
2. After scenario 1, WRITE 0x17 data 0x5A.
   - No stall.
   - line5 byte3=0x5A, dirty=1.
   - A subsequent READ 0x17 returns 0x5A.
3. READ 0x34 (same index 5, tag 1) while line5 is dirty.
   - WRITEBACK: MEM_ADDRESS=0x05, MEM_WRITEDATA=0x5ACCBBAA.
   - Then FETCH at MEM_ADDRESS=0x0D.
   - BUSYWAIT high for 11 posedges.
   - Afterwards dirty=0.
4. WRITE miss to 0xE0 with data 0x77 on an invalid line.
   - FETCH at MEM_ADDRESS=0x38.
   - After the fill: byte0=0x77, dirty=1, other bytes come from memory.
5. Assert RESET in the 3rd FETCH cycle.
   - MEM_READ drops at that edge; state returns to IDLE.
   - A READ of the same address after reset misses again.
6. READ and WRITE both high on a hit to 0x01 with data 0x99.
   - Treated as a write: byte updated to 0x99, dirty=1.
